sub_serial32: RTL



---
 rtl/sub_serial32.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sub_serial32.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial32
// Purpose  : Multi-cycle two's-complement subtractor, diff = a - b over WIDTH
//            bits. One SLICE-bit chunk is processed per clock, LSB chunk
//            first. A registered carry links consecutive chunks.
//            Valid/ready handshakes are provided on the input and output sides.
// Ports    : clk       - single clock, rising edge
//            reset     - synchronous, active-high
//            in_valid  - operands a/b valid
//            in_ready  - block can accept operands (IDLE and not in reset)
//            a, b      - minuend, subtrahend (WIDTH bits)
//            out_valid - result valid (held until out_ready)
//            out_ready - consumer accepts the result
//            diff      - a - b modulo 2^WIDTH
//            borrow    - 1 iff a < b (unsigned)
//            overflow  - signed overflow of a - b
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    // WIDTH must be a whole multiple of SLICE.
    localparam int c_nslice = WIDTH / SLICE;
    // Keep the index at least one bit wide so NSLICE=1 remains legal.
    localparam int c_idx_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nslice - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;        // holds ~b so subtraction becomes addition
    logic [WIDTH-1:0]     r_diff;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic                 r_out_valid;
    logic                 r_borrow;
    logic                 r_overflow;

    logic [SLICE-1:0]     w_a_chunk;
    logic [SLICE-1:0]     w_b_chunk;
    logic [SLICE:0]       w_sum;

    assign w_a_chunk = r_a[r_idx*SLICE +: SLICE];
    assign w_b_chunk = r_b[r_idx*SLICE +: SLICE];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{SLICE{1'b0}}, r_carry};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_overflow  <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= ~b;
                        r_carry <= 1'b1;   // the +1 of the two's-complement negate
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_diff[r_idx*SLICE +: SLICE] <= w_sum[SLICE-1:0];
                    r_carry <= w_sum[SLICE];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        // No carry out of a + ~b + 1 means the subtraction borrowed.
                        r_borrow    <= ~w_sum[SLICE];
                        // Operand signs differ (a MSB equals the inverted b MSB)
                        // and the result sign departs from the minuend sign.
                        r_overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &
                                       (w_sum[SLICE-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Gated by reset so the producer never sees ready while reset is high.
    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
